// File: rtl/ram_2port_loader_pkg.sv
// Shared definitions for the runtime-loadable lookup table RAM:
// default widths, loader state encoding and beats-per-entry helper.
package ram_2port_loader_pkg;

  localparam int unsigned DEF_DWIDTH = 64;
  localparam int unsigned DEF_AWIDTH = 8;
  localparam int unsigned DEF_SWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } load_state_e;

  function automatic int unsigned wpe_f(input int unsigned dwidth,
                                        input int unsigned swidth);
    return (dwidth + swidth - 1) / swidth;
  endfunction

endpackage

// File: rtl/ram_2port_rw.sv
// Single-write, dual registered-read RAM with 2-cycle read latency.
// Reads are read-first: a colliding write shows up on the following read.
module ram_2port_rw
  import ram_2port_loader_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned MEM_SIZE  = 2**AWIDTH,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [AWIDTH-1:0] address_b,
  output logic [DWIDTH-1:0] q_a,
  output logic [DWIDTH-1:0] q_b
);

  logic [DWIDTH-1:0] mem [MEM_SIZE];
  logic [AWIDTH-1:0] addr_a_q, addr_b_q;
  logic [DWIDTH-1:0] q_a_q, q_b_q;

  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      q_a_q    <= '0;
      q_b_q    <= '0;
    end else begin
      addr_a_q <= address_a;
      addr_b_q <= address_b;
      q_a_q    <= mem[addr_a_q];
      q_b_q    <= mem[addr_b_q];
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/ram_2port_loader.sv
// Streaming loader: packs SWIDTH beats little-endian into DWIDTH entries and
// writes them sequentially from a programmable base; two registered read ports.
module ram_2port_loader
  import ram_2port_loader_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned MEM_SIZE  = 2**AWIDTH,
  parameter string       INIT_FILE = "",
  parameter int unsigned SWIDTH    = DEF_SWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cfg_addr,
  input  logic              cfg_addr_valid,
  input  logic [SWIDTH-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [AWIDTH-1:0] address_b,
  output logic [DWIDTH-1:0] q_a,
  output logic [DWIDTH-1:0] q_b,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [AWIDTH:0]   load_count
);

  localparam int unsigned WPE = wpe_f(DWIDTH, SWIDTH);
  localparam int unsigned BW  = WPE * SWIDTH;
  localparam int unsigned CW  = (WPE > 1) ? $clog2(WPE) : 1;
  localparam logic [CW-1:0]     WCNT_MAX  = CW'(WPE - 1);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  load_state_e       state_q, state_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic              we_q, we_d;
  logic              wlast_q, wlast_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [AWIDTH:0]   load_count_q, load_count_d;
  logic              load_err_q, load_err_d;
  logic              load_busy_q, load_busy_d;
  logic              load_done_q, load_done_d;
  logic [AWIDTH-1:0] base_q, base_d;

  logic [CW-1:0]     cur_wcnt;
  logic [AWIDTH-1:0] cur_addr;
  logic [BW-1:0]     cur_buf;
  logic [AWIDTH:0]   cur_count;
  logic              beat_ok;
  logic              entry_done;

  assign s_ready = ~rst;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wcnt_d       = wcnt_q;
    buf_d        = buf_q;
    we_d         = 1'b0;
    wlast_d      = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    load_busy_d  = load_busy_q;
    load_done_d  = we_q & wlast_q;
    base_d       = base_q;
    cur_wcnt     = wcnt_q;
    cur_addr     = wr_addr_q;
    cur_count    = load_count_q;
    beat_ok      = s_valid & s_ready;

    if (load_done_d) load_busy_d = 1'b0;

    // The IDLE beat is beat 0 of the new load, so it is packed with
    // the freshly selected base exactly like a FILL beat.
    if (state_q == IDLE) begin
      if (cfg_addr_valid) base_d = cfg_addr;
      cur_wcnt  = '0;
      cur_addr  = base_d;
      cur_count = '0;
    end

    cur_buf = (cur_wcnt == '0) ? '0 : buf_q;
    cur_buf[cur_wcnt*SWIDTH +: SWIDTH] = s_data;
    entry_done = (cur_wcnt == WCNT_MAX) | s_last;

    if (beat_ok) begin
      case (state_q)
        IDLE, FILL: begin
          if (state_q == IDLE) begin
            load_busy_d  = 1'b1;
            load_err_d   = 1'b0;
            load_count_d = '0;
          end
          if (entry_done) begin
            we_d         = 1'b1;
            wlast_d      = s_last;
            waddr_d      = cur_addr;
            wdata_d      = cur_buf[DWIDTH-1:0];
            wr_addr_d    = cur_addr + 1'b1;
            wcnt_d       = '0;
            load_count_d = cur_count + 1'b1;
            if (s_last) begin
              state_d = IDLE;
            end else if (cur_addr == LAST_ADDR) begin
              load_err_d = 1'b1;
              state_d    = DRAIN;
            end else begin
              state_d = FILL;
            end
          end else begin
            wr_addr_d = cur_addr;
            wcnt_d    = cur_wcnt + 1'b1;
            buf_d     = cur_buf;
            state_d   = FILL;
          end
        end
        DRAIN: begin
          if (s_last) begin
            load_done_d = 1'b1;
            load_busy_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      wcnt_q       <= '0;
      buf_q        <= '0;
      we_q         <= 1'b0;
      wlast_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wcnt_q       <= wcnt_d;
      buf_q        <= buf_d;
      we_q         <= we_d;
      wlast_q      <= wlast_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
      base_q       <= base_d;
    end
  end

  assign load_busy  = load_busy_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign load_count = load_count_q;

  ram_2port_rw #(
    .DWIDTH   (DWIDTH),
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (we_q),
    .waddr    (waddr_q),
    .wdata    (wdata_q),
    .address_a(address_a),
    .address_b(address_b),
    .q_a      (q_a),
    .q_b      (q_b)
  );

endmodule

// File: tb/tb_ram_2port_loader.sv
// Directed bench for ram_2port_loader with a beat-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_ram_2port_loader;

  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int SW  = 32;
  localparam int MS  = 16;
  localparam int WPE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cfg_addr;
  logic          cfg_addr_valid;
  logic [SW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [AW-1:0] address_a;
  logic [AW-1:0] address_b;
  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;

  always #5 clk = ~clk;

  ram_2port_loader #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .MEM_SIZE (MS),
    .INIT_FILE(""),
    .SWIDTH   (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_addr      (cfg_addr),
    .cfg_addr_valid(cfg_addr_valid),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .address_a     (address_a),
    .address_b     (address_b),
    .q_a           (q_a),
    .q_b           (q_b),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err),
    .load_count    (load_count)
  );

  int nchecks  = 0;
  int nerrs    = 0;
  int done_cnt = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a load is a numbered beat sequence; beat n lands in
  // entry base + n/WPE, slot n%WPE; beats past the last entry are dropped.
  logic [63:0] m_mem [MS];
  bit          m_known [MS];
  logic [3:0]  m_ra, m_rb, m_base, m_ld_base, p_addr;
  logic [63:0] m_qa, m_qb, p_data, m_acc;
  bit          m_ka, m_kb, m_active, m_busy, m_done, m_err, p_we, p_last;
  int          m_nb, m_cnt;

  always @(posedge clk) begin
    int tgt;
    int slot;
    bit dn;
    dn = 0;
    if (rst) begin
      m_qa = '0; m_qb = '0; m_ka = 1; m_kb = 1;
      m_ra = '0; m_rb = '0; m_base = '0;
      p_we = 0; m_active = 0; m_busy = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_qa = m_mem[m_ra]; m_ka = m_known[m_ra];
      m_qb = m_mem[m_rb]; m_kb = m_known[m_rb];
      m_ra = address_a;   m_rb = address_b;
      if (p_we) begin
        m_mem[p_addr] = p_data;
        m_known[p_addr] = 1;
        dn = p_last;
        p_we = 0;
      end
      if (dn) m_busy = 0;
      if (!m_active && cfg_addr_valid) m_base = cfg_addr;
      if (s_valid) begin
        if (!m_active) begin
          m_ld_base = m_base; m_nb = 0; m_cnt = 0; m_err = 0;
          m_active = 1; m_busy = 1;
        end
        tgt  = int'(m_ld_base) + m_nb / WPE;
        slot = m_nb % WPE;
        if (tgt < MS) begin
          if (slot == 0) m_acc = '0;
          m_acc[slot*SW +: SW] = s_data;
          if (slot == WPE - 1 || s_last) begin
            p_we = 1; p_addr = 4'(tgt); p_data = m_acc; p_last = s_last;
            m_cnt++;
            if (!s_last && tgt == MS - 1) m_err = 1;
          end
        end else if (s_last) begin
          dn = 1;
          m_busy = 0;
        end
        m_nb++;
        if (s_last) m_active = 0;
      end
    end
    m_done = dn;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", s_ready, !rst);
      if (m_ka) chk("q_a", q_a, m_qa);
      if (m_kb) chk("q_b", q_b, m_qb);
      chk("load_done", load_done, m_done);
      chk("load_busy", load_busy, m_busy);
      if (load_done) done_cnt++;
    end
  end

  task automatic set_base(input logic [AW-1:0] a);
    cfg_addr = a; cfg_addr_valid = 1;
    @(posedge clk); #1;
    cfg_addr_valid = 0;
  endtask

  task automatic beat(input logic [SW-1:0] d, input bit last);
    s_data = d; s_valid = 1; s_last = last;
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                    input logic [63:0] ea, input logic [63:0] eb, input string nm);
    address_a = aa; address_b = ab;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({nm, "_qa"}, q_a, ea);
    chk({nm, "_qb"}, q_b, eb);
  endtask

  task automatic finish_load(input string nm, input int d0, input int ecnt, input bit eerr);
    int k;
    k = 0;
    while (load_busy === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk({nm, "_timeout"}, (k < 20), 1);
    chk({nm, "_count"}, load_count, ecnt);
    chk({nm, "_err"}, load_err, eerr);
    chk({nm, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    cfg_addr = '0; cfg_addr_valid = 0; s_data = '0; s_valid = 0; s_last = 0;
    address_a = '0; address_b = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_a", q_a, 0);
    chk("rst_q_b", q_b, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_count", load_count, 0);
    chk_en = 1;
    rst = 0;
    @(posedge clk); #1;

    // Fill every entry; final entry carries s_last so no overflow.
    d0 = done_cnt;
    set_base(0);
    for (int j = 0; j < 32; j++) beat(32'hA000_0000 | j, j == 31);
    finish_load("t0", d0, 16, 0);
    rd(0, 15, 64'hA0000001_A0000000, 64'hA000001F_A000001E, "t0_rd");

    // Scenario 1
    d0 = done_cnt;
    set_base(2);
    beat(32'h11111111, 0); beat(32'h22222222, 0);
    beat(32'h33333333, 0); beat(32'h44444444, 1);
    finish_load("t1", d0, 2, 0);
    rd(2, 3, 64'h22222222_11111111, 64'h44444444_33333333, "t1_rd");

    // Scenario 2: base supplied together with the first beat
    d0 = done_cnt;
    cfg_addr = 5; cfg_addr_valid = 1;
    beat(32'hA, 0);
    cfg_addr_valid = 0;
    beat(32'hB, 0); beat(32'hC, 1);
    finish_load("t2", d0, 2, 0);
    rd(5, 6, 64'h0000000B_0000000A, 64'h00000000_0000000C, "t2_rd");

    // Scenario 3: overflow past the last entry
    d0 = done_cnt;
    set_base(14);
    for (int j = 0; j < 6; j++) beat(32'hE0 + j, j == 5);
    finish_load("t3", d0, 2, 1);
    rd(14, 15, 64'h000000E1_000000E0, 64'h000000E3_000000E2, "t3_rd");
    rd(0, 0, 64'hA0000001_A0000000, 64'hA0000001_A0000000, "t3_nowrap");

    // Scenario 4: read-during-write returns old data
    address_a = 3;
    d0 = done_cnt;
    set_base(3);
    beat(32'h1, 0); beat(32'h0, 1);
    finish_load("t4a", d0, 1, 0);
    chk("t4_pre", q_a, 64'h1);
    d0 = done_cnt;
    set_base(3);
    beat(32'h2, 0); beat(32'h0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_collide", q_a, 64'h1);
    @(negedge clk);
    chk("t4_new", q_a, 64'h2);
    finish_load("t4b", d0, 1, 0);

    // Scenario 5: reset mid-load, then mid-load cfg is ignored
    set_base(7);
    beat(32'h55, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("t5_busy", load_busy, 0);
    chk("t5_count", load_count, 0);
    rd(7, 7, 64'hA000000F_A000000E, 64'hA000000F_A000000E, "t5_keep");
    d0 = done_cnt;
    set_base(7);
    beat(32'h77, 0);
    cfg_addr = 9; cfg_addr_valid = 1;
    beat(32'h78, 1);
    cfg_addr_valid = 0;
    finish_load("t5", d0, 1, 0);
    rd(7, 9, 64'h00000078_00000077, 64'hA0000013_A0000012, "t5_rd");

    // Scenario 6: scenario 1 with s_valid gaps
    d0 = done_cnt;
    set_base(2);
    beat(32'h11111111, 0); @(posedge clk); #1;
    beat(32'h22222222, 0); @(posedge clk); #1;
    beat(32'h33333333, 0); @(posedge clk); #1;
    beat(32'h44444444, 1);
    finish_load("t6", d0, 2, 0);
    rd(2, 3, 64'h22222222_11111111, 64'h44444444_33333333, "t6_rd");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
